// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// byte-lane helpers used by both the alignment datapath and the controller.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    // Byte-lane mask for a byte (is_half=0) or halfword (is_half=1) at the given offset.
    function automatic logic [31:0] lane_mask(input logic is_half, input logic [1:0] offset);
        logic [31:0] base;
        base = is_half ? 32'h0000_FFFF : 32'h0000_00FF;
        return base << {offset, 3'b000};
    endfunction

    // True for the five funct3 encodings that name a real access size.
    function automatic logic f3_defined(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // True when the access size does not fit its natural alignment.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        if (funct3 == F3_W)
            bad = (offset != 2'b00);
        else if ((funct3 == F3_H) || (funct3 == F3_HU))
            bad = offset[0];
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends sub-word loads from the
// memory word, and merges sub-word store data into the old memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] rdata_shifted;
    logic [31:0] wdata_shifted;
    logic [31:0] mask;

    assign rdata_shifted = mem_rdata >> {offset, 3'b000};
    assign wdata_shifted = wdata << {offset, 3'b000};
    // Only SB (000) and SH (001) reach the merge path, so funct3[0] picks the size.
    assign mask = lane_mask(funct3[0], offset);

    // Load extraction: the addressed lane is moved to bit 0, then extended.
    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            F3_BU:   load_data = {24'h0, rdata_shifted[7:0]};
            F3_H:    load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            F3_HU:   load_data = {16'h0, rdata_shifted[15:0]};
            F3_W:    load_data = mem_rdata;
            default: load_data = 32'h0;
        endcase
    end

    // Store merge, one byte lane at a time: new byte where masked, old byte elsewhere.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge_lane
            assign merge_data[8*gi +: 8] = mask[8*gi] ? wdata_shifted[8*gi +: 8]
                                                      : mem_rdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the monocycle core and a word-only data memory.
// Loads are zero-latency; SB/SH become a two-cycle read-modify-write that
// stalls the core for one cycle. Misaligned or undefined requests are dropped.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              misaligned,
    output logic [CNT_W-1:0]  rmw_count,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_t        state_reg, state_next;
    logic [31:0]       merge_reg, merge_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [ADDR_W-1:0] aligned_addr;
    logic              req_bad;
    logic              store_word;
    logic              store_sub;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign aligned_addr = {cpu_addr[ADDR_W-1:2], 2'b00};

    // Unsigned stores do not exist, so BU/HU with cpu_we are dropped like undefined codes.
    assign req_bad    = !f3_defined(cpu_funct3) ||
                        addr_misaligned(cpu_funct3, cpu_addr[1:0]) ||
                        (cpu_we && cpu_funct3[2]);
    assign store_word = (cpu_funct3 == F3_W);
    assign store_sub  = (cpu_funct3 == F3_B) || (cpu_funct3 == F3_H);

    lsu_align u_align (
        .funct3     (cpu_funct3),
        .offset     (cpu_addr[1:0]),
        .mem_rdata  (mem_read_data),
        .wdata      (cpu_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state and output decode; everything is held quiet while reset is high.
    always_comb begin
        state_next     = state_reg;
        merge_next     = merge_reg;
        addr_next      = addr_reg;
        count_next     = count_reg;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = aligned_addr;
        mem_write_data = cpu_wdata;
        cpu_stall      = 1'b0;
        misaligned     = 1'b0;
        cpu_rdata      = 32'h0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        if (req_bad) begin
                            misaligned = 1'b1;
                        end else if (!cpu_we) begin
                            mem_read  = 1'b1;
                            cpu_rdata = load_data;
                        end else if (store_word) begin
                            mem_write = 1'b1;
                        end else if (store_sub) begin
                            mem_read   = 1'b1;
                            cpu_stall  = 1'b1;
                            merge_next = merge_data;
                            addr_next  = aligned_addr;
                            state_next = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    // The core is still presenting the same store; its inputs are ignored here.
                    mem_write      = 1'b1;
                    mem_address    = addr_reg;
                    mem_write_data = merge_reg;
                    if (count_reg != {CNT_W{1'b1}})
                        count_next = count_reg + CNT_W'(1);
                    state_next     = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, merge buffer, target address and event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            merge_reg <= 32'h0;
            addr_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            merge_reg <= merge_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
        end
    end

    assign rmw_count = count_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of single-cycle accesses,
// then hand-written read-modify-write, reset-abort and saturation sequences.
module tb_load_store_unit;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_funct3;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              misaligned;
    logic [CNT_W-1:0]  rmw_count;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_funct3     (cpu_funct3),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .misaligned     (misaligned),
        .rmw_count      (rmw_count),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-only data memory: combinational read, write on the clock edge.
    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_write)
            mem[mem_address[9:2]] <= mem_write_data;
    end

    typedef struct {
        logic        req;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req    = req;
        cpu_we     = we;
        cpu_funct3 = f3;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
    endtask

    // Two-cycle sub-word store: checks the read/stall cycle, the write cycle and the aftermath.
    task automatic rmw_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_merge, input logic [31:0] exp_count);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        @(negedge clk);
        drive(1'b1, 1'b1, f3, addr, wdata);
        #1;
        check("rmw_n_stall", {31'b0, cpu_stall}, 32'h1);
        check("rmw_n_read", {31'b0, mem_read}, 32'h1);
        check("rmw_n_write", {31'b0, mem_write}, 32'h0);
        check("rmw_n_addr", mem_address, waddr);
        @(negedge clk);
        #1;
        check("rmw_n1_write", {31'b0, mem_write}, 32'h1);
        check("rmw_n1_read", {31'b0, mem_read}, 32'h0);
        check("rmw_n1_stall", {31'b0, cpu_stall}, 32'h0);
        check("rmw_n1_addr", mem_address, waddr);
        check("rmw_n1_wdata", mem_write_data, exp_merge);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("rmw_count", {{(32-CNT_W){1'b0}}, rmw_count}, exp_count);
        check("rmw_mem", mem[waddr[9:2]], exp_merge);
        $display("rmw f3=%b addr=%h wdata=%h -> merge=%h count=%0d", f3, addr, wdata,
                 mem_write_data, rmw_count);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[0] <= 32'h8844_2211;
        mem[1] <= 32'h0000_0005;

        //        req   we    f3      addr   wdata         rdata         mis   rd    wr
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'd3, 32'h0,        32'hFFFF_FF88, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'd3, 32'h0,        32'h0000_0088, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b001, 32'd2, 32'h0,        32'hFFFF_8844, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'd0, 32'h0,        32'h0000_2211, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'd0, 32'h0,        32'h8844_2211, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'd1, 32'h0,        32'h0000_0022, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'd2, 32'h0,        32'h0000_8844, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'b001, 32'd0, 32'h0,        32'h0000_2211, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'd2, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'b001, 32'd3, 32'h1234,     32'h0,         1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b001, 32'd1, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'd0, 32'h0,        32'h0,         1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'd8, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'd8, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 3'b010, 32'd0, 32'h0,        32'h0,         1'b0, 1'b0, 1'b0};

        // Reset with a request that would otherwise be flagged misaligned.
        reset = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'd2, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read", {31'b0, mem_read}, 32'h0);
        check("rst_write", {31'b0, mem_write}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_mis", {31'b0, misaligned}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_count", {{(32-CNT_W){1'b0}}, rmw_count}, 32'h0);
        $display("reset: read=%b write=%b stall=%b mis=%b", mem_read, mem_write, cpu_stall, misaligned);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            #1;
            check("vec_rdata", cpu_rdata, vecs[i].exp_rdata);
            check("vec_mis", {31'b0, misaligned}, {31'b0, vecs[i].exp_mis});
            check("vec_read", {31'b0, mem_read}, {31'b0, vecs[i].exp_rd});
            check("vec_write", {31'b0, mem_write}, {31'b0, vecs[i].exp_wr});
            check("vec_stall", {31'b0, cpu_stall}, 32'h0);
            if (vecs[i].exp_rd || vecs[i].exp_wr)
                check("vec_addr", mem_address, {vecs[i].addr[31:2], 2'b00});
            if (vecs[i].exp_wr)
                check("vec_wdata", mem_write_data, vecs[i].wdata);
            $display("vec %0d: req=%b we=%b f3=%b addr=%h -> rdata=%h mis=%b rd=%b wr=%b",
                     i, vecs[i].req, vecs[i].we, vecs[i].f3, vecs[i].addr,
                     cpu_rdata, misaligned, mem_read, mem_write);
        end
        @(negedge clk);
        check("mis_count", {{(32-CNT_W){1'b0}}, rmw_count}, 32'h0);

        // SB 0xAB at addr 1 over 0x8844_2211; SH 0xBEEF at addr 6 over 0x0000_0005.
        rmw_store(3'b000, 32'd1, 32'h0000_00AB, 32'h8844_AB11, 32'd1);
        rmw_store(3'b001, 32'd6, 32'h0000_BEEF, 32'hBEEF_0005, 32'd2);

        // Reset lands in the write cycle of an SB to word 2: nothing is written.
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b000, 32'd8, 32'h0000_0077);
        #1;
        check("abort_stall", {31'b0, cpu_stall}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_write", {31'b0, mem_write}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("abort_count", {{(32-CNT_W){1'b0}}, rmw_count}, 32'h0);
        check("abort_mem", mem[2], 32'hDEAD_BEEF);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        #1;
        check("abort_idle_read", {31'b0, mem_read}, 32'h1);
        check("abort_idle_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("abort_idle_stall", {31'b0, cpu_stall}, 32'h0);
        $display("reset-abort: mem[2]=%h count=%0d", mem[2], rmw_count);

        // Sixteen SB stores into word 3: the 4-bit counter must stop at 15.
        for (int i = 0; i < 16; i++) begin
            rmw_store(3'b000, 32'd12, 32'(i), 32'(i), (i < 15) ? 32'(i + 1) : 32'd15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
